pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central pipeline sequencer for the 16-bit five-stage core.
- Drives write-enable/bubble/flush controls for PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves three event classes: load-use hazards (1-cycle stall), taken branches (multi-cycle squash), instruction/data cache misses (full freeze with timeout).
- Its id_ex_write output is the sole source of the ID/EX register's load enable; id_ex_bubble forces that register's control fields to zero.

Parameters:
- REG_W, 3, register index width.
- FLUSH_CYCLES, 2, cycles of ID/EX bubble after a taken branch (range 1..7).
- MISS_TIMEOUT, 255, max consecutive miss cycles before fault (8-bit counter).

Ports:
- clk  input  1  core clock; controller state updates on posedge (pipeline registers capture on negedge).
- rst_n  input  1  asynchronous active-low reset.
- id_rs  input  REG_W  source reg 1 of instruction in ID.
- id_rt  input  REG_W  source reg 2 of instruction in ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_dst  input  REG_W  destination reg of instruction in EX.
- branch_taken  input  1  branch resolved taken in MEM.
- hit  input  1  both caches hit this cycle.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID clear.
- id_ex_write  output  1  ID/EX load enable.
- id_ex_bubble  output  1  zero ID/EX control fields.
- ex_mem_flush  output  1  zero EX/MEM control fields.
- miss_fault  output  1  sticky miss-timeout fault.

Behaviour:
- Clock/reset: one clock, clk; asynchronous active-low reset, rst_n. Reset forces state RUN, miss counter 0, flush counter 0.
- Reset output values: pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=0, id_ex_bubble=0, ex_mem_flush=0, miss_fault=0.
- FSM states: RUN, FLUSH, MISS_WAIT, FAULT. Outputs are decoded combinationally from state plus current inputs (Mealy), so a hazard takes effect in the same cycle it is detected.
- load_use = ex_mem_read && ex_dst!=0 && ((id_uses_rs && id_rs==ex_dst) || (id_uses_rt && id_rt==ex_dst)). Register 0 never hazards.
- Priority each cycle: hit=0 > branch_taken > load_use.
- RUN, hit=0:
  - All write enables 0; no flush/bubble.
  - Next state MISS_WAIT, miss counter=1.
- RUN, branch_taken:
  - pc_write=1, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1.
  - Next state FLUSH, flush counter=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, stay in RUN.
- RUN, load_use:
  - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1.
  - Remain RUN; the hazard clears when the load advances.
- FLUSH:
  - id_ex_bubble=1, if_id_flush=1, pc_write=1.
  - Counter decrements; return to RUN at 0.
  - hit=0 in FLUSH: freeze, go to MISS_WAIT; the remaining flush count is discarded.
  - branch_taken in FLUSH is ignored (it is a squashed instruction).
- MISS_WAIT:
  - Full freeze; counter increments each cycle.
  - hit=1 → RUN. The same cycle applies RUN rules, so a branch held during the freeze is acted on then.
  - Counter reaching MISS_TIMEOUT with hit=0 → FAULT.
- FAULT:
  - Full freeze, miss_fault=1.
  - Exit only via rst_n.
- Reset asserted in any state returns to RUN immediately (asynchronous); outputs revert to their reset values.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles (16-bit) and flush_events (16-bit).
  - stall_cycles increments on every cycle with pc_write=0.
  - flush_events increments on each RUN→branch event.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg: state enum (RUN, FLUSH, MISS_WAIT, FAULT, 2-bit), REG_ZERO constant, REG_W default.
- One sub-module, hazard_cmp: purely combinational load_use detector. FSM and counters stay in the top module.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst=3, id_rs=3, id_uses_rs=1, hit=1 → exactly one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; normal flow the next cycle.
- R0 exclusion: same as above with ex_dst=0, id_rs=0 → no stall, pc_write=1.
- Branch: branch_taken pulse 1 cycle, FLUSH_CYCLES=2 → if_id_flush=1 and id_ex_bubble=1 for 2 cycles, ex_mem_flush=1 for the first cycle only.
- Miss + branch: hit=0 for 5 cycles with branch_taken held 1 → 5 frozen cycles with no flush; on hit=1, branch squash starts that cycle.
- Timeout: MISS_TIMEOUT=4, hit=0 held → miss_fault=1 after 4 miss cycles, stays 1 after hit=1; rst_n pulse clears it.
- Reset mid-FLUSH: assert rst_n=0 during FLUSH → all outputs take reset values immediately; RUN on release.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Purpose : Shared types and constants for the pipeline hazard controller.
//           Holds the sequencer state encoding, the hard-wired zero register
//           index and the default register-index width.
// Ports   : none (package)
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  // Default register index width for the 16-bit five-stage core
  localparam int REG_W_DEFAULT = 3;

  // Register 0 is hard-wired to zero and can never create a data hazard
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_FAULT     = 2'd3
  } hz_state_e;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/hazard_cmp.sv
// ============================================================================
// Module  : hazard_cmp
// Purpose : Purely combinational load-use hazard detector. Flags when the
//           load in EX writes a register the instruction in ID reads.
// Ports   : id_rs, id_rt       - source registers of the ID instruction
//           id_uses_rs/_rt     - ID instruction actually reads rs / rt
//           ex_mem_read        - EX instruction is a load
//           ex_dst             - destination register of the EX instruction
//           load_use           - hazard detected
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  output logic             load_use
);

  logic dst_nonzero;
  logic rs_match;
  logic rt_match;

  assign dst_nonzero = (ex_dst != REG_W'(REG_ZERO));
  assign rs_match    = id_uses_rs && (id_rs == ex_dst);
  assign rt_match    = id_uses_rt && (id_rt == ex_dst);
  assign load_use    = ex_mem_read && dst_nonzero && (rs_match || rt_match);

endmodule : hazard_cmp

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Purpose : Central sequencer for the five-stage core. Produces the PC,
//           IF/ID, ID/EX and EX/MEM load/clear controls for load-use stalls,
//           taken-branch squashes and cache-miss freezes (with timeout fault).
//           Outputs are Mealy: decoded from state plus the current inputs.
// Ports   : clk, rst_n (async, active low)
//           id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_dst
//           branch_taken, hit
//           pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
//           ex_mem_flush, miss_fault
//           stall_cycles, flush_events (only with HAZARD_PERF_CNT_EN)
// Config  : `define HAZARD_PERF_CNT_EN adds saturating performance counters.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W        = REG_W_DEFAULT,
  parameter int FLUSH_CYCLES = 2,
  parameter int MISS_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             branch_taken,
  input  logic             hit,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_events,
`endif
  output logic             miss_fault
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [8:0] MISS_LIMIT = 9'(MISS_TIMEOUT);

  hz_state_e  state, state_nxt;
  logic [7:0] miss_cnt, miss_cnt_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [8:0] miss_inc;
  logic       load_use;
  logic       run_rules;
  logic       enter_miss;
  logic       freeze;
  logic       branch_evt;

  hazard_cmp #(
    .REG_W (REG_W)
  ) u_cmp (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_dst      (ex_dst),
    .load_use    (load_use)
  );

  // Widened so the comparison against a limit of 255 cannot wrap
  assign miss_inc = {1'b0, miss_cnt} + 9'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      miss_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      miss_cnt  <= miss_cnt_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    miss_cnt_nxt  = miss_cnt;
    flush_cnt_nxt = flush_cnt;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_flush  = 1'b0;
    miss_fault    = 1'b0;
    run_rules     = 1'b0;
    enter_miss    = 1'b0;
    freeze        = 1'b0;
    branch_evt    = 1'b0;

    case (state)
      ST_RUN: begin
        run_rules = 1'b1;
      end
      ST_FLUSH: begin
        if (!hit) begin
          // A miss wins over the squash; leftover flush count is dropped
          enter_miss = 1'b1;
        end else begin
          // Any branch seen here belongs to a squashed instruction
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          flush_cnt_nxt = flush_cnt - 3'd1;
          if (flush_cnt <= 3'd1) begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_MISS_WAIT: begin
        if (hit) begin
          // Miss resolved: this same cycle is handled exactly like RUN
          run_rules    = 1'b1;
          miss_cnt_nxt = '0;
          state_nxt    = ST_RUN;
        end else begin
          freeze       = 1'b1;
          miss_cnt_nxt = miss_inc[7:0];
          if (miss_inc >= MISS_LIMIT) begin
            state_nxt = ST_FAULT;
          end
        end
      end
      ST_FAULT: begin
        freeze     = 1'b1;
        miss_fault = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase

    if (run_rules) begin
      if (!hit) begin
        enter_miss = 1'b1;
      end else if (branch_taken) begin
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        ex_mem_flush  = 1'b1;
        branch_evt    = 1'b1;
        flush_cnt_nxt = FLUSH_INIT;
        state_nxt     = (FLUSH_CYCLES <= 1) ? ST_RUN : ST_FLUSH;
      end else if (load_use) begin
        // Hold PC and IF/ID, let ID/EX load a bubble behind the load
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end

    if (enter_miss) begin
      freeze        = 1'b1;
      miss_cnt_nxt  = 8'd1;
      flush_cnt_nxt = '0;
      state_nxt     = (MISS_TIMEOUT <= 1) ? ST_FAULT : ST_MISS_WAIT;
    end

    if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
    end

    // While reset is held the outputs show their reset values regardless
    // of the Mealy decode of the live inputs
    if (!rst_n) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_bubble = 1'b0;
      ex_mem_flush = 1'b0;
      miss_fault   = 1'b0;
      branch_evt   = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      if (branch_evt && (flush_events != 16'hFFFF)) begin
        flush_events <= flush_events + 16'd1;
      end
    end
  end
`else
  // Counters absent; the branch event strobe has no consumer
  logic unused_branch_evt;
  assign unused_branch_evt = branch_evt;
`endif

endmodule : pipeline_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Purpose : Self-checking bench for pipeline_hazard_ctrl (default build).
//           Directed scenarios followed by randomized traffic, each cycle
//           compared against a behavioural model of the sequencing rules.
// Ports   : none
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int RW = 3;
  localparam int FC = 2;
  localparam int MT = 4;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write,
  //                       id_ex_bubble, ex_mem_flush, miss_fault}
  localparam logic [6:0] O_NORMAL = 7'b1101000;
  localparam logic [6:0] O_FREEZE = 7'b0000000;
  localparam logic [6:0] O_FAULT  = 7'b0000001;
  localparam logic [6:0] O_BRANCH = 7'b1111110;
  localparam logic [6:0] O_SQUASH = 7'b1111100;
  localparam logic [6:0] O_STALL  = 7'b0001100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] id_rs, id_rt, ex_dst;
  logic          id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, hit;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write;
  logic          id_ex_bubble, ex_mem_flush, miss_fault;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: consecutive miss cycles seen, squash cycles still owed, fault latch
  int m_miss_run;
  int m_squash;
  bit m_faulted;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W        (RW),
    .FLUSH_CYCLES (FC),
    .MISS_TIMEOUT (MT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_dst       (ex_dst),
    .branch_taken (branch_taken),
    .hit          (hit),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_write  (id_ex_write),
    .id_ex_bubble (id_ex_bubble),
    .ex_mem_flush (ex_mem_flush),
    .miss_fault   (miss_fault)
  );

  task automatic set_idle();
    hit          = 1'b1;
    branch_taken = 1'b0;
    ex_mem_read  = 1'b0;
    ex_dst       = '0;
    id_rs        = '0;
    id_rt        = '0;
    id_uses_rs   = 1'b0;
    id_uses_rt   = 1'b0;
  endtask

  task automatic model_reset();
    m_miss_run = 0;
    m_squash   = 0;
    m_faulted  = 1'b0;
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_write,
           id_ex_bubble, ex_mem_flush, miss_fault};
    n_cmp++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  // Called just after a falling edge with inputs already applied: checks
  // this cycle's outputs, advances the model, then moves to the next fall.
  task automatic step(input string tag);
    logic [6:0] exp;
    bit lu;
    #1;
    lu = ex_mem_read && (ex_dst != 0) &&
         ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    exp = O_NORMAL;
    if (m_faulted) begin
      exp = O_FAULT;
    end else if (!hit) begin
      exp = O_FREEZE;
      m_miss_run++;
      m_squash = 0;
      if (m_miss_run >= MT) m_faulted = 1'b1;
    end else begin
      m_miss_run = 0;
      if (m_squash > 0) begin
        exp = O_SQUASH;
        m_squash--;
      end else if (branch_taken) begin
        exp = O_BRANCH;
        m_squash = FC - 1;
      end else if (lu) begin
        exp = O_STALL;
      end
    end
    check(tag, exp);
    @(negedge clk);
  endtask

  // Asserts reset mid-cycle, checks outputs respond at once, releases on
  // the next falling edge.
  task automatic reset_chk(input string tag);
    rst_n = 1'b0;
    #1;
    check(tag, O_NORMAL);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    model_reset();
    // Hazard inputs present while in reset must not show through
    ex_mem_read = 1'b1; ex_dst = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    @(negedge clk);
    reset_chk("reset_vals");
    set_idle();
    step("idle");

    // Load-use on rs: one stall cycle, then normal once the load moves on
    ex_mem_read = 1'b1; ex_dst = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    step("lu_stall");
    ex_mem_read = 1'b0;
    step("lu_after");

    // Load-use on rt, and a matching rt that is not read
    set_idle();
    ex_mem_read = 1'b1; ex_dst = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1;
    step("lu_rt");
    id_uses_rt = 1'b0;
    step("lu_rt_unused");

    // Register 0 never hazards
    set_idle();
    ex_mem_read = 1'b1; ex_dst = 3'd0; id_rs = 3'd0; id_uses_rs = 1'b1;
    step("r0_exclude");

    // Branch pulse: two cycles of squash, EX/MEM flushed only first cycle
    set_idle();
    branch_taken = 1'b1;
    step("br_first");
    branch_taken = 1'b0;
    step("br_flush");
    step("br_done");

    // Branch seen during FLUSH is ignored; branch beats load-use
    branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_dst = 3'd2; id_rs = 3'd2; id_uses_rs = 1'b1;
    step("br_over_lu");
    step("br_in_flush");
    set_idle();
    step("br_in_flush_done");

    // Miss with branch held: frozen, squash begins on the hit cycle
    set_idle();
    branch_taken = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < MT - 1; i++) step("mb_freeze");
    hit = 1'b1;
    step("mb_squash");
    branch_taken = 1'b0;
    step("mb_flush");
    step("mb_done");

    // Miss during FLUSH discards the remaining squash
    branch_taken = 1'b1;
    step("fm_branch");
    branch_taken = 1'b0;
    hit = 1'b0;
    step("fm_miss");
    hit = 1'b1;
    step("fm_resume");

    // Timeout: fault after MT consecutive misses, sticky until reset
    hit = 1'b0;
    for (int i = 0; i < MT + 1; i++) step("to_miss");
    hit = 1'b1;
    step("to_sticky");
    step("to_sticky2");
    reset_chk("to_clear");
    step("to_after_rst");

    // Reset while squashing
    branch_taken = 1'b1;
    step("rf_branch");
    branch_taken = 1'b0;
    reset_chk("rf_reset");
    step("rf_run");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      hit          = ($urandom_range(0, 7) != 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      ex_mem_read  = $urandom_range(0, 1) == 1;
      ex_dst       = RW'($urandom_range(0, 7));
      id_rs        = RW'($urandom_range(0, 7));
      id_rt        = RW'($urandom_range(0, 7));
      id_uses_rs   = $urandom_range(0, 1) == 1;
      id_uses_rt   = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) reset_chk("rnd_reset");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl

`default_nettype wire
